// File: rtl/clean_row_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : clean_row_scheduler
// Function : Frame-level sequencer that pushes every row of the frame buffer
//            through the row cleaner and writes the cleaned rows back.
//            Build macro CLEAN_TIMEOUT_EN adds a per-row WAIT timeout that
//            passes the raw row through and raises a sticky timeout_err.
// Revision : 1.0  initial release
// ============================================================================
module clean_row_scheduler #(
    parameter int WIDTH   = 480,
    parameter int HEIGHT  = 320,
    parameter int ADDR_W  = 9,
    parameter int RD_LAT  = 2,
    parameter int TIMEOUT = 2047
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_frame,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data,
    output logic              cleaner_rst,
    output logic              start_cleaning,
    output logic [WIDTH-1:0]  pattern_out,
    input  logic              cleaner_valid,
    input  logic [WIDTH-1:0]  cleaner_pattern,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              timeout_err
);

    if (RD_LAT < 1 || RD_LAT > 7 || HEIGHT < 1 || (1 << ADDR_W) < HEIGHT || TIMEOUT < 1)
    begin : g_param_check
        $error("clean_row_scheduler: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LOAD  = 3'd2,
        S_CRST  = 3'd3,
        S_START = 3'd4,
        S_WAIT  = 3'd5,
        S_WRITE = 3'd6,
        S_NEXT  = 3'd7
    } state_t;

    localparam logic [2:0]        LAT_LAST = 3'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(HEIGHT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [2:0]        lat_q, lat_d;
    logic              rst_pend_q;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              crst_q, crst_d;
    logic              start_q, start_d;
    logic [WIDTH-1:0]  pattern_q, pattern_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]  wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

`ifdef CLEAN_TIMEOUT_EN
    localparam int              TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_err_q, tmo_err_d;
`endif

    // Outputs are computed for the state being entered, so every strobe is
    // registered and lines up with the cycle its state is occupied.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        lat_d     = lat_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        crst_d    = rst_pend_q;
        start_d   = 1'b0;
        pattern_d = pattern_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef CLEAN_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        tmo_err_d = tmo_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                // The post-reset cleaner_rst cycle owns the strobe slot.
                if (start_frame && !rst_pend_q) begin
                    row_d     = '0;
                    busy_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                    state_d   = S_READ;
`ifdef CLEAN_TIMEOUT_EN
                    tmo_err_d = 1'b0;
`endif
                end
            end
            S_READ: begin
                lat_d   = '0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (lat_q == LAT_LAST) begin
                    pattern_d = rd_data;
                    crst_d    = 1'b1;
                    state_d   = S_CRST;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            S_CRST: begin
                start_d = 1'b1;
                state_d = S_START;
            end
            S_START: begin
                state_d = S_WAIT;
`ifdef CLEAN_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (cleaner_valid) begin
                    wr_data_d = cleaner_pattern;
                    wr_en_d   = 1'b1;
                    wr_addr_d = row_q;
                    state_d   = S_WRITE;
                end
`ifdef CLEAN_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    wr_data_d = pattern_q;
                    tmo_err_d = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = row_q;
                    state_d   = S_WRITE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            S_WRITE: begin
                if (row_q == ROW_LAST) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (row_q == ROW_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    row_d     = row_q + 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = row_q + 1'b1;
                    state_d   = S_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            lat_q      <= '0;
            rst_pend_q <= 1'b1;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            crst_q     <= 1'b0;
            start_q    <= 1'b0;
            pattern_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            lat_q      <= lat_d;
            rst_pend_q <= 1'b0;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            crst_q     <= crst_d;
            start_q    <= start_d;
            pattern_q  <= pattern_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef CLEAN_TIMEOUT_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign rd_en          = rd_en_q;
    assign rd_addr        = rd_addr_q;
    assign cleaner_rst    = crst_q;
    assign start_cleaning = start_q;
    assign pattern_out    = pattern_q;
    assign wr_en          = wr_en_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign busy           = busy_q;
    assign frame_done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_clean_row_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_clean_row_scheduler
// Function : Randomized scoreboard bench for clean_row_scheduler with frame
//            buffer and cleaner models. Define CLEAN_TIMEOUT_EN for timeouts.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_clean_row_scheduler;

    localparam int WIDTH   = 480;
    localparam int HEIGHT  = 4;
    localparam int ADDR_W  = 2;
    localparam int RD_LAT  = 2;
    localparam int TIMEOUT = 100;
    localparam int SILENT  = 1 << 29;
`ifdef CLEAN_TIMEOUT_EN
    localparam int TMO = TIMEOUT;
`else
    localparam int TMO = 1 << 30;
`endif

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic              start_frame = 1'b0;
    logic [WIDTH-1:0]  rd_data = '0;
    logic              cleaner_valid = 1'b0;
    logic [WIDTH-1:0]  cleaner_pattern = '0;
    logic              rd_en, cleaner_rst, start_cleaning, wr_en;
    logic              busy, frame_done, timeout_err;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [WIDTH-1:0]  pattern_out, wr_data;

    clean_row_scheduler #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W),
        .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_frame(start_frame),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .cleaner_rst(cleaner_rst), .start_cleaning(start_cleaning),
        .pattern_out(pattern_out), .cleaner_valid(cleaner_valid),
        .cleaner_pattern(cleaner_pattern), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .frame_done(frame_done),
        .timeout_err(timeout_err)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [WIDTH-1:0] mem [HEIGHT];
    int               lat_tbl [HEIGHT];

    // Scoreboard queues filled when a frame is requested
    int               exp_rd_q[$];
    int               exp_wa_q[$];
    logic [WIDTH-1:0] exp_wd_q[$];
    bit               exp_tmo = 1'b0;

    bit mon_en = 1'b0;
    int start_cycle = 0, busy_from = 0, busy_to = 0, done_cycle = -1, fd_cnt = 0;
    int last_rd = 0, last_st = 0, last_wr = 0, m_row = 0;
    logic [WIDTH-1:0] st_pat = '0;
    bit waiting = 1'b0;

    int               due_q[$];
    int               due_addr_q[$];
    int               resp_at = -1;
    int               env_row = 0;
    logic [WIDTH-1:0] resp_pat = '0;

    function automatic logic [WIDTH-1:0] rand_row();
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < WIDTH / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int eff_lat(input int l);
        return (l > TMO) ? TMO : l;
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_row(input string name, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk_in);
        cyc++;
    end

    // Frame buffer and cleaner models
    initial forever begin
        @(negedge clk_in);
        if (rst_in) begin
            due_q.delete();
            due_addr_q.delete();
            resp_at = -1;
        end
        rd_data = rand_row();
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            rd_data = mem[due_addr_q[0]];
            void'(due_q.pop_front());
            void'(due_addr_q.pop_front());
        end
        if (rd_en) begin
            due_q.push_back(cyc + RD_LAT);
            due_addr_q.push_back(int'(rd_addr));
            env_row = int'(rd_addr);
        end
        cleaner_valid   = 1'b0;
        cleaner_pattern = rand_row();
        if (start_cleaning) begin
            resp_at  = (lat_tbl[env_row] >= SILENT) ? -1 : cyc + lat_tbl[env_row];
            resp_pat = ~pattern_out;
        end
        if (resp_at == cyc) begin
            cleaner_valid   = 1'b1;
            cleaner_pattern = resp_pat;
            resp_at         = -1;
        end else if (rd_en && $urandom_range(0, 1) == 1) begin
            cleaner_valid = 1'b1;
        end
    end

    // Monitor: pops expectations whenever the DUT strobes
    initial forever begin
        @(negedge clk_in);
        if (mon_en) begin
            check_int("strobe_onehot",
                      ($countones({rd_en, cleaner_rst, start_cleaning, wr_en}) <= 1) ? 1 : 0, 1);
            check_int("busy", int'(busy), (cyc >= busy_from && cyc < busy_to) ? 1 : 0);
            if (rd_en) begin
                if (exp_rd_q.size() == 0) begin
                    check_int("rd_unexpected", int'(rd_addr), -1);
                end else begin
                    m_row = exp_rd_q.pop_front();
                    check_int("rd_addr", int'(rd_addr), m_row);
                    check_int("rd_time", cyc, (m_row == 0) ? start_cycle + 1 : last_wr + 2);
                end
                last_rd = cyc;
            end
            if (cleaner_rst) check_int("crst_time", cyc, last_rd + RD_LAT + 1);
            if (start_cleaning) begin
                check_int("start_time", cyc, last_rd + RD_LAT + 2);
                check_row("pattern_load", pattern_out, mem[m_row]);
                st_pat  = pattern_out;
                last_st = cyc;
                waiting = 1'b1;
            end else if (waiting && !wr_en) begin
                check_row("pattern_hold", pattern_out, st_pat);
            end
            if (wr_en) begin
                waiting = 1'b0;
                if (exp_wa_q.size() == 0) begin
                    check_int("wr_unexpected", int'(wr_addr), -1);
                end else begin
                    int               a;
                    logic [WIDTH-1:0] d;
                    a = exp_wa_q.pop_front();
                    d = exp_wd_q.pop_front();
                    check_int("wr_addr", int'(wr_addr), a);
                    check_row("wr_data", wr_data, d);
                    check_int("wr_time", cyc, last_st + eff_lat(lat_tbl[a]) + 1);
                    if (a == HEIGHT - 1) begin
                        done_cycle = cyc + 1;
                        busy_to    = cyc + 1;
                    end
                end
                last_wr = cyc;
            end
            if (frame_done || cyc == done_cycle) begin
                check_int("frame_done_time", int'(frame_done), (cyc == done_cycle) ? 1 : 0);
                if (frame_done) fd_cnt++;
            end
        end
    end

    task automatic check_reset_vals(input string name);
        check_int(name, int'({rd_en, rd_addr, cleaner_rst, start_cleaning, wr_en, wr_addr,
                              busy, frame_done, timeout_err}), 0);
        check_row({name, "_pattern"}, pattern_out, '0);
        check_row({name, "_wr_data"}, wr_data, '0);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        mon_en = 1'b0;
        rst_in = 1'b1;
        @(negedge clk_in);
        check_reset_vals("reset_vals");
        @(negedge clk_in);
        rst_in = 1'b0;
        exp_rd_q.delete();
        exp_wa_q.delete();
        exp_wd_q.delete();
        waiting    = 1'b0;
        busy_to    = 0;
        done_cycle = -1;
        @(negedge clk_in);
        check_int("post_rst_crst", int'(cleaner_rst), 1);
        check_int("post_rst_others", int'({rd_en, start_cleaning, wr_en, busy}), 0);
        @(negedge clk_in);
        check_int("post_rst_crst_end", int'(cleaner_rst), 0);
        mon_en = 1'b1;
    endtask

    task automatic randomize_frame();
        for (int r = 0; r < HEIGHT; r++) begin
            mem[r]     = rand_row();
            lat_tbl[r] = int'($urandom_range(1, 40));
        end
    endtask

    task automatic issue_frame();
        @(negedge clk_in);
        start_frame = 1'b1;
        start_cycle = cyc;
        busy_from   = cyc + 1;
        busy_to     = 1 << 30;
        done_cycle  = -1;
        exp_tmo     = 1'b0;
        for (int r = 0; r < HEIGHT; r++) begin
            exp_rd_q.push_back(r);
            exp_wa_q.push_back(r);
            exp_wd_q.push_back((lat_tbl[r] > TMO) ? mem[r] : ~mem[r]);
            if (lat_tbl[r] > TMO) exp_tmo = 1'b1;
        end
        @(negedge clk_in);
        start_frame = 1'b0;
        check_int("tmo_cleared_on_start", int'(timeout_err), 0);
    endtask

    task automatic wait_done(input int n_before);
        int t;
        t = 0;
        while (fd_cnt == n_before && t < 20000) begin
            @(negedge clk_in);
            t++;
        end
        repeat (3) @(negedge clk_in);
        check_int("frame_done_count", fd_cnt, n_before + 1);
        check_int("rd_queue_empty", exp_rd_q.size(), 0);
        check_int("wr_queue_empty", exp_wa_q.size(), 0);
        check_int("timeout_err", int'(timeout_err), int'(exp_tmo));
    endtask

    task automatic wait_row_start(input int row);
        int t;
        t = 0;
        do begin
            @(negedge clk_in);
            t++;
        end while (!(start_cleaning && int'(rd_addr) == row) && t < 5000);
        check_int("row_start_seen", (t < 5000) ? 1 : 0, 1);
    endtask

    initial begin
        do_reset();
        repeat (2) @(negedge clk_in);

        // Long cleaner passes; row 0 carries the 5A pattern
        randomize_frame();
        for (int r = 0; r < HEIGHT; r++) lat_tbl[r] = 960;
        mem[0] = {(WIDTH / 8){8'h5A}};
        issue_frame();
        wait_done(0);

        // start_frame during WAIT of row 1 must be ignored
        randomize_frame();
        lat_tbl[1] = 30;
        issue_frame();
        wait_row_start(1);
        @(negedge clk_in);
        start_frame = 1'b1;
        @(negedge clk_in);
        start_frame = 1'b0;
        wait_done(1);

        // Reset in WAIT of row 2 abandons the frame
        randomize_frame();
        lat_tbl[2] = 200;
        issue_frame();
        wait_row_start(2);
        repeat (5) @(negedge clk_in);
        do_reset();
        check_int("no_done_after_abort", fd_cnt, 2);
        repeat (2) @(negedge clk_in);

        randomize_frame();
        issue_frame();
        wait_done(2);

`ifdef CLEAN_TIMEOUT_EN
        randomize_frame();
        lat_tbl[1] = SILENT;
        issue_frame();
        wait_done(3);

        randomize_frame();
        lat_tbl[0] = TIMEOUT;
        issue_frame();
        wait_done(4);

        randomize_frame();
        lat_tbl[2] = TIMEOUT + 1;
        issue_frame();
        wait_done(5);

        for (int k = 0; k < 2; k++) begin
            randomize_frame();
            issue_frame();
            wait_done(6 + k);
        end
`else
        for (int k = 0; k < 3; k++) begin
            randomize_frame();
            issue_frame();
            wait_done(3 + k);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clean_row_scheduler.md
Name: clean_row_scheduler

Overview:
- Frame-level controller for the row cleaner.
- Walks every row of the binarized frame buffer in order. For each row it:
  - fetches the row,
  - resets the cleaner, loads the row and starts it,
  - waits for the cleaner's valid pulse,
  - writes the cleaned row back to the output row buffer.
- Sits between the binarization/frame-buffer stage and the finder-pattern locator. It is the only master of the cleaner.

Parameters:
- WIDTH, 480, pixels per row; cleaner pattern width.
- HEIGHT, 320, rows per frame.
- ADDR_W, 9, row-address width; must satisfy 2**ADDR_W >= HEIGHT.
- RD_LAT, 2, cycles from rd_en to valid rd_data; legal range 1..7.
- TIMEOUT, 2047, maximum WAIT cycles per row (optional feature only).

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous active-high reset.
- start_frame  in  1  one-cycle request to process a frame.
- rd_en  out  1  row read strobe to the input frame buffer.
- rd_addr  out  ADDR_W  row index to read.
- rd_data  in  WIDTH  row data, valid RD_LAT cycles after rd_en.
- cleaner_rst  out  1  one-cycle reset to the cleaner.
- start_cleaning  out  1  one-cycle start to the cleaner.
- pattern_out  out  WIDTH  row fed to the cleaner; held stable until the cleaner's valid arrives.
- cleaner_valid  in  1  cleaner done pulse.
- cleaner_pattern  in  WIDTH  cleaned row.
- wr_en  out  1  write strobe to the output row buffer.
- wr_addr  out  ADDR_W  row index written.
- wr_data  out  WIDTH  cleaned row written.
- busy  out  1  high from frame accept until frame_done.
- frame_done  out  1  one-cycle pulse after the last row is written.
- timeout_err  out  1  sticky; set on a row timeout; cleared by start_frame (optional feature only).

Behaviour:
- All outputs are registered.
- Reset values: all strobes 0, busy 0, rd_addr/wr_addr 0, pattern_out 0, wr_data 0, timeout_err 0, row counter 0, state IDLE.
- Reset mid-frame:
  - Abandon the frame: return to IDLE with reset values, no frame_done.
  - Also drive cleaner_rst=1 on the first cycle after rst_in deasserts, so the cleaner cannot be left in its terminal state.
- States: IDLE, READ, LOAD, CRST, START, WAIT, WRITE, NEXT.
- IDLE:
  - start_frame=1 → row=0, busy=1, go to READ.
  - start_frame while busy is ignored. No queueing.
- READ:
  - rd_en=1 and rd_addr=row for exactly one cycle.
  - Go to LOAD.
- LOAD:
  - Count RD_LAT-1 cycles, then capture rd_data into pattern_out.
  - Go to CRST.
- CRST: cleaner_rst=1 for one cycle, then go to START.
- START: start_cleaning=1 for one cycle, then go to WAIT.
- WAIT:
  - Hold pattern_out. The cleaner samples it throughout its pass.
  - On cleaner_valid=1: capture cleaner_pattern into wr_data and go to WRITE.
  - cleaner_valid outside WAIT is ignored.
- WRITE:
  - wr_en=1 and wr_addr=row for one cycle.
  - Go to NEXT.
- NEXT:
  - If row==HEIGHT-1: frame_done=1 for one cycle, busy=0, go to IDLE.
  - Otherwise: row=row+1, go to READ.
  - The row counter never wraps within a frame.
- Latency from start_frame to the first rd_en: 1 cycle.
- Per-row overhead outside the cleaner: RD_LAT + 5 cycles.
- Only one of rd_en, cleaner_rst, start_cleaning, wr_en is high in any cycle.

Optional Feature:
- Macro: CLEAN_TIMEOUT_EN.
- With the macro defined:
  - The WAIT counter resets on WAIT entry.
  - If it reaches TIMEOUT without cleaner_valid:
    - set timeout_err,
    - go to WRITE with wr_data = pattern_out (raw row passed through),
    - continue with the next row.
  - cleaner_valid arriving in the same cycle as the timeout takes priority: the cleaned data is written and timeout_err is not set.
- Without the macro: WAIT waits indefinitely; timeout_err is tied to 0; no counter logic is synthesized.

Test Plan:
- HEIGHT=4, RD_LAT=2, cleaner model responds 960 cycles after start:
  - start_frame → rd_addr 0,1,2,3 in order;
  - wr_addr 0..3 with the model's data;
  - a single frame_done after wr_addr=3;
  - busy high throughout.
- Row 0 rd_data = 480'h5A5A…, cleaner returns ~rd_data → wr_data equals ~rd_data; pattern_out stable from START until cleaner_valid.
- start_frame pulsed during WAIT of row 1 → ignored; exactly 4 writes and 1 frame_done.
- rst_in asserted in WAIT of row 2 →
  - the next cycle shows all reset values;
  - cleaner_rst=1 on the first cycle after reset deasserts;
  - a new start_frame restarts at rd_addr 0.
- CLEAN_TIMEOUT_EN, TIMEOUT=100, cleaner silent on row 1 →
  - timeout_err=1;
  - wr_addr 1 gets the raw row;
  - rows 2,3 complete normally;
  - the next start_frame clears timeout_err.
- CLEAN_TIMEOUT_EN, cleaner_valid on the exact timeout cycle → cleaned data written, timeout_err stays 0.
